// File: rtl/dmx_rx_bus_pkg.sv
// ---------------------------------------------------------------------------
// dmx_rx_bus_pkg
// Shared definitions for the DMX512 receiver: default line timing at
// 48 MHz / 250 kbaud, the universe size, and the state encodings of the
// frame FSM (dmx_rx_bus) and the byte receiver (dmx_uart_rx).
// ---------------------------------------------------------------------------
package dmx_rx_bus_pkg;

    localparam int DMX_CLOCKS_PER_BIT   = 192;   // 48 MHz / 250 kbaud
    localparam int DMX_BREAK_MIN_CYCLES = 4224;  // 88 us
    localparam int DMX_MAB_MIN_CYCLES   = 384;   // 8 us
    localparam int DMX_MAX_SLOTS        = 512;
    localparam int SLOT_COUNT_WIDTH     = 10;    // holds 0..512

    // Frame-level states.
    typedef enum logic [2:0] {
        ST_WAIT_BREAK,
        ST_BREAK,
        ST_MAB,
        ST_START_SLOT,
        ST_DATA_SLOTS
    } dmx_state_t;

    // Byte receiver states. RX_HOLD parks an all-zero byte with a low stop
    // bit until the line settles: it is either the start of a break (the
    // frame FSM's low-run counter claims it) or a framing error.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_HOLD
    } rx_state_t;

endpackage

// File: rtl/dmx_uart_rx.sv
// ---------------------------------------------------------------------------
// dmx_uart_rx
// 8N2 LSB-first byte receiver for the DMX line.
//   clk, rst       system clock, synchronous active-high reset
//   dmx_in         raw asynchronous line (idle high)
//   enable         receive allowed; low forces the receiver idle
//   line           2-flop synchronised line, shared with the frame FSM
//   byte_valid     high in the stop-bit sample cycle when the stop bit is high
//   rx_byte        assembled byte, valid with byte_valid
//   framing_error  high for one cycle when a byte ends with a low stop bit
// ---------------------------------------------------------------------------
module dmx_uart_rx
    import dmx_rx_bus_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = DMX_CLOCKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dmx_in,
    input  logic       enable,
    output logic       line,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       framing_error
);

    localparam int CNT_W = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);

    logic [1:0]       sync_q;
    logic             line_prev;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] tick_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             stop_sample;

    assign line        = sync_q[1];
    assign rx_byte     = shift_q;
    assign stop_sample = (rx_state == RX_STOP) && (tick_cnt == BIT_LAST);
    assign byte_valid  = stop_sample && line;
    // A zero byte with a low stop bit may be the leading edge of a break, so
    // its error is deferred until the line returns high.
    assign framing_error = (stop_sample && !line && (shift_q != 8'h00)) ||
                           ((rx_state == RX_HOLD) && line);

    // Synchroniser resets to the idle (high) level so reset never looks
    // like a falling edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of the others, whatever the block order.
        if (rst) begin
            sync_q    <= 2'b11;
            line_prev <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], dmx_in};
            line_prev <= sync_q[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            rx_state <= RX_IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (line_prev && !line) begin
                        rx_state <= RX_START;
                        tick_cnt <= '0;
                    end
                end
                RX_START: begin
                    // Mid start bit: a line already back high was a glitch.
                    if (tick_cnt == HALF_LAST) begin
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        rx_state <= line ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_cnt <= '0;
                        shift_q  <= {line, shift_q[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_cnt <= '0;
                        rx_state <= (!line && (shift_q == 8'h00)) ? RX_HOLD : RX_IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                RX_HOLD: begin
                    if (line) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dmx_rx_bus.sv
// ---------------------------------------------------------------------------
// dmx_rx_bus
// DMX512 receiver that packs slot bytes in pairs onto the 16-bit word write
// bus feeding sram_bus.
//   clk, rst          system clock, synchronous active-high reset
//   dmx_in            raw asynchronous DMX line (idle high)
//   write_address     word address, BASE_ADDRESS + slot pair index
//   write_data        [7:0] odd channel, [15:8] even channel
//   write_strobe      one-cycle write qualifier (no backpressure)
//   frame_strobe      one-cycle pulse at the end of an accepted frame
//   frame_slot_count  data slots in the last accepted frame, held
//   error_strobe      one-cycle pulse on framing error or short MAB
// ---------------------------------------------------------------------------
module dmx_rx_bus
    import dmx_rx_bus_pkg::*;
#(
    parameter int                           CLOCKS_PER_BIT    = DMX_CLOCKS_PER_BIT,
    parameter int                           BREAK_MIN_CYCLES  = DMX_BREAK_MIN_CYCLES,
    parameter int                           MAB_MIN_CYCLES    = DMX_MAB_MIN_CYCLES,
    parameter int                           ADDRESS_BUS_WIDTH = 16,
    parameter logic [ADDRESS_BUS_WIDTH-1:0] BASE_ADDRESS      = 16'h7F00,
    parameter logic [7:0]                   START_CODE        = 8'h00
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dmx_in,
    output logic [ADDRESS_BUS_WIDTH-1:0] write_address,
    output logic [15:0]                  write_data,
    output logic                         write_strobe,
    output logic                         frame_strobe,
    output logic [SLOT_COUNT_WIDTH-1:0]  frame_slot_count,
    output logic                         error_strobe
);

    localparam int LOW_W = $clog2(BREAK_MIN_CYCLES + 1);
    localparam int MAB_W = $clog2(MAB_MIN_CYCLES + 1);
    localparam logic [LOW_W-1:0] LOW_MAX  = LOW_W'(BREAK_MIN_CYCLES);
    localparam logic [LOW_W-1:0] LOW_HIT  = LOW_W'(BREAK_MIN_CYCLES - 1);
    localparam logic [MAB_W-1:0] MAB_LAST = MAB_W'(MAB_MIN_CYCLES - 1);
    localparam logic [SLOT_COUNT_WIDTH-1:0] LAST_SLOT = SLOT_COUNT_WIDTH'(DMX_MAX_SLOTS - 1);

    logic                        line;
    logic                        byte_valid;
    logic                        framing_error;
    logic [7:0]                  rx_byte;
    logic                        rx_enable;
    logic                        break_hit;
    dmx_state_t                  state;
    logic [LOW_W-1:0]            low_run;
    logic [MAB_W-1:0]            mab_cnt;
    logic [SLOT_COUNT_WIDTH-1:0] slot_idx;
    logic [7:0]                  pending;
    logic                        frame_done_pending;  // frame_strobe due next cycle

    assign rx_enable = (state == ST_START_SLOT) || (state == ST_DATA_SLOTS);
    assign break_hit = !line && (low_run == LOW_HIT);

    dmx_uart_rx #(
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
    ) u_uart (
        .clk           (clk),
        .rst           (rst),
        .dmx_in        (dmx_in),
        .enable        (rx_enable),
        .line          (line),
        .byte_valid    (byte_valid),
        .rx_byte       (rx_byte),
        .framing_error (framing_error)
    );

    // Consecutive low cycles, saturating so a long break fires only once.
    always_ff @(posedge clk) begin
        if (rst || line)             low_run <= '0;
        else if (low_run != LOW_MAX) low_run <= low_run + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_WAIT_BREAK;
            mab_cnt            <= '0;
            slot_idx           <= '0;
            pending            <= '0;
            frame_done_pending <= 1'b0;
            write_address      <= '0;
            write_data         <= '0;
            write_strobe       <= 1'b0;
            frame_strobe       <= 1'b0;
            frame_slot_count   <= '0;
            error_strobe       <= 1'b0;
        end else begin
            write_strobe       <= 1'b0;
            frame_strobe       <= 1'b0;
            error_strobe       <= 1'b0;
            frame_done_pending <= 1'b0;

            // Deferred so the final write and frame_strobe never coincide.
            if (frame_done_pending) begin
                frame_strobe     <= 1'b1;
                frame_slot_count <= slot_idx;
            end

            if (break_hit) begin
                if (state == ST_DATA_SLOTS) begin
                    if (slot_idx[0]) begin
                        // Odd slot count: flush the unpaired byte first.
                        write_address      <= BASE_ADDRESS + ADDRESS_BUS_WIDTH'(slot_idx >> 1);
                        write_data         <= {8'h00, pending};
                        write_strobe       <= 1'b1;
                        frame_done_pending <= 1'b1;
                    end else begin
                        frame_strobe     <= 1'b1;
                        frame_slot_count <= slot_idx;
                    end
                end
                state <= ST_BREAK;
            end else begin
                case (state)
                    ST_WAIT_BREAK: ;
                    ST_BREAK: begin
                        if (line) begin
                            state   <= ST_MAB;
                            mab_cnt <= '0;
                        end
                    end
                    ST_MAB: begin
                        if (!line) begin
                            error_strobe <= 1'b1;
                            state        <= ST_WAIT_BREAK;
                        end else if (mab_cnt == MAB_LAST) begin
                            state <= ST_START_SLOT;
                        end else begin
                            mab_cnt <= mab_cnt + 1'b1;
                        end
                    end
                    ST_START_SLOT: begin
                        if (framing_error) begin
                            error_strobe <= 1'b1;
                            state        <= ST_WAIT_BREAK;
                        end else if (byte_valid) begin
                            // Foreign start codes are skipped silently.
                            if (rx_byte == START_CODE) begin
                                state    <= ST_DATA_SLOTS;
                                slot_idx <= '0;
                            end else begin
                                state <= ST_WAIT_BREAK;
                            end
                        end
                    end
                    ST_DATA_SLOTS: begin
                        if (framing_error) begin
                            error_strobe <= 1'b1;
                            state        <= ST_WAIT_BREAK;
                        end else if (byte_valid) begin
                            if (!slot_idx[0]) begin
                                pending <= rx_byte;
                            end else begin
                                write_address <= BASE_ADDRESS + ADDRESS_BUS_WIDTH'(slot_idx >> 1);
                                write_data    <= {rx_byte, pending};
                                write_strobe  <= 1'b1;
                            end
                            slot_idx <= slot_idx + 1'b1;
                            if (slot_idx == LAST_SLOT) begin
                                frame_done_pending <= 1'b1;
                                state              <= ST_WAIT_BREAK;
                            end
                        end
                    end
                    default: state <= ST_WAIT_BREAK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmx_rx_bus.sv
// ---------------------------------------------------------------------------
// tb_dmx_rx_bus
// Drives DMX frames bit by bit (timing scaled down: 4 clocks per bit, 88-cycle
// break minimum, 8-cycle MAB minimum) and compares the observed bus writes,
// frame strobes and error strobes with a slot-list model of the universe.
// ---------------------------------------------------------------------------
module tb_dmx_rx_bus;

    localparam int          CPB  = 4;
    localparam int          BRK  = 88;
    localparam int          MABC = 8;
    localparam logic [15:0] BASE = 16'h7F00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dmx_in = 1'b1;
    logic [15:0] write_address;
    logic [15:0] write_data;
    logic        write_strobe;
    logic        frame_strobe;
    logic [9:0]  frame_slot_count;
    logic        error_strobe;

    dmx_rx_bus #(
        .CLOCKS_PER_BIT    (CPB),
        .BREAK_MIN_CYCLES  (BRK),
        .MAB_MIN_CYCLES    (MABC),
        .ADDRESS_BUS_WIDTH (16),
        .BASE_ADDRESS      (BASE),
        .START_CODE        (8'h00)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .dmx_in           (dmx_in),
        .write_address    (write_address),
        .write_data       (write_data),
        .write_strobe     (write_strobe),
        .frame_strobe     (frame_strobe),
        .frame_slot_count (frame_slot_count),
        .error_strobe     (error_strobe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- observation (opposite clock edge) ----------------
    int unsigned cyc = 0;
    logic [15:0] obs_addr[$];
    logic [15:0] obs_data[$];
    int unsigned obs_wcyc[$];
    int unsigned obs_fcount[$];
    int unsigned obs_fcyc[$];
    int          obs_errs = 0;
    int          overlap  = 0;

    always @(negedge clk) begin
        cyc++;
        if (write_strobe === 1'b1) begin
            obs_addr.push_back(write_address);
            obs_data.push_back(write_data);
            obs_wcyc.push_back(cyc);
        end
        if (frame_strobe === 1'b1) begin
            obs_fcount.push_back(32'(frame_slot_count));
            obs_fcyc.push_back(cyc);
        end
        if (error_strobe === 1'b1) obs_errs++;
        if (write_strobe === 1'b1 && frame_strobe === 1'b1) overlap++;
    end

    // ---------------- reference model ----------------
    logic [7:0]  slots[512];
    logic [15:0] exp_addr[$];
    logic [15:0] exp_data[$];

    // Writes produced by the first m accepted slots; flush pairs a trailing
    // odd slot with 0x00 when the frame is closed by a break.
    task automatic model_writes(input int m, input bit flush);
        exp_addr.delete();
        exp_data.delete();
        for (int j = 0; j < m / 2; j++) begin
            exp_addr.push_back(BASE + 16'(j));
            exp_data.push_back({slots[2*j+1], slots[2*j]});
        end
        if (flush && (m % 2 == 1)) begin
            exp_addr.push_back(BASE + 16'(m / 2));
            exp_data.push_back({8'h00, slots[m-1]});
        end
    endtask

    task automatic verify(input string tag, input int exp_frames, input int exp_count,
                          input int exp_errs, input bit adjacent);
        int n;
        check({tag, "/writes"}, obs_addr.size(), exp_addr.size());
        n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s/addr%0d", tag, i), obs_addr[i], exp_addr[i]);
            check($sformatf("%s/data%0d", tag, i), obs_data[i], exp_data[i]);
        end
        check({tag, "/frames"}, obs_fcount.size(), exp_frames);
        if (exp_frames > 0 && obs_fcount.size() > 0) begin
            check({tag, "/slot_count"}, obs_fcount[0], exp_count);
            if (adjacent && obs_wcyc.size() > 0)
                check({tag, "/strobe_gap"}, obs_fcyc[0] - obs_wcyc[obs_wcyc.size()-1], 1);
        end
        check({tag, "/errors"}, obs_errs, exp_errs);
        obs_addr.delete();
        obs_data.delete();
        obs_wcyc.delete();
        obs_fcount.delete();
        obs_fcyc.delete();
        obs_errs = 0;
    endtask

    // ---------------- line stimulus ----------------
    task automatic drive(input logic v, input int cycles);
        dmx_in = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        if (good_stop) begin
            drive(1'b1, 2 * CPB + int'($urandom_range(0, 6)));
        end else begin
            drive(1'b0, CPB);
            drive(1'b1, 3 * CPB);
        end
    endtask

    task automatic frame_head(input int brk, input int mab, input logic [7:0] sc);
        drive(1'b0, brk);
        drive(1'b1, mab);
        send_byte(sc, 1'b1);
    endtask

    task automatic end_frame();
        drive(1'b0, 100);
        drive(1'b1, 24);
    endtask

    task automatic randomize_slots(input int n);
        for (int i = 0; i < n; i++) slots[i] = 8'($urandom);
    endtask

    task automatic run_frame(input string tag, input int n);
        frame_head(100, 12, 8'h00);
        for (int i = 0; i < n; i++) send_byte(slots[i], 1'b1);
        end_frame();
        model_writes(n, 1'b1);
        verify(tag, 1, n, 0, (n % 2) == 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset/write_strobe", write_strobe, 0);
        check("reset/frame_strobe", frame_strobe, 0);
        check("reset/error_strobe", error_strobe, 0);
        check("reset/write_address", write_address, 0);
        check("reset/write_data", write_data, 0);
        check("reset/slot_count", frame_slot_count, 0);
        rst = 1'b0;
        drive(1'b1, 20);

        // Four slots, even count: two writes, frame_strobe on break detect.
        slots[0] = 8'h11; slots[1] = 8'h22; slots[2] = 8'h33; slots[3] = 8'h44;
        run_frame("four_slots", 4);

        // Reset in the middle of slot index 4: no flush, outputs cleared.
        randomize_slots(8);
        frame_head(100, 12, 8'h00);
        for (int i = 0; i < 4; i++) send_byte(slots[i], 1'b1);
        drive(1'b0, CPB);
        drive(slots[4][0], CPB);
        drive(slots[4][1], CPB);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst/write_strobe", write_strobe, 0);
        check("midrst/frame_strobe", frame_strobe, 0);
        check("midrst/error_strobe", error_strobe, 0);
        check("midrst/write_address", write_address, 0);
        check("midrst/write_data", write_data, 0);
        check("midrst/slot_count", frame_slot_count, 0);
        rst = 1'b0;
        for (int i = 2; i < 8; i++) drive(slots[4][i], CPB);
        drive(1'b1, 2 * CPB);
        for (int i = 5; i < 8; i++) send_byte(slots[i], 1'b1);
        end_frame();
        model_writes(4, 1'b0);
        verify("midrst", 0, 0, 0, 1'b0);

        randomize_slots(12);
        run_frame("after_rst", 12);

        // Odd count: flush write, then frame_strobe the next cycle.
        slots[0] = 8'hAA; slots[1] = 8'hBB; slots[2] = 8'hCC;
        run_frame("three_slots", 3);

        // Full universe; extra bytes after slot 512 must be ignored.
        for (int i = 0; i < 512; i++) slots[i] = 8'(i + 1);
        frame_head(100, 12, 8'h00);
        for (int i = 0; i < 512; i++) send_byte(slots[i], 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        end_frame();
        model_writes(512, 1'b1);
        verify("full512", 1, 512, 0, 1'b1);

        // Foreign start code: silently ignored.
        randomize_slots(4);
        frame_head(100, 12, 8'hCC);
        for (int i = 0; i < 4; i++) send_byte(slots[i], 1'b1);
        end_frame();
        model_writes(0, 1'b0);
        verify("startcode_cc", 0, 0, 0, 1'b0);

        randomize_slots(6);
        run_frame("after_cc", 6);

        // Low stop bit on slot index 2.
        randomize_slots(3);
        frame_head(100, 12, 8'h00);
        send_byte(slots[0], 1'b1);
        send_byte(slots[1], 1'b1);
        send_byte(slots[2], 1'b0);
        drive(1'b1, 30);
        model_writes(2, 1'b0);
        verify("bad_stop", 0, 0, 1, 1'b0);

        // 80-cycle low is too short to be a break.
        randomize_slots(4);
        drive(1'b0, 80);
        drive(1'b1, 12);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(slots[i], 1'b1);
        drive(1'b1, 20);
        model_writes(0, 1'b0);
        verify("short_break", 0, 0, 0, 1'b0);

        // 4-cycle MAB is too short.
        drive(1'b0, 100);
        drive(1'b1, 4);
        send_byte(8'h00, 1'b1);
        send_byte(slots[0], 1'b1);
        send_byte(slots[1], 1'b1);
        drive(1'b1, 20);
        model_writes(0, 1'b0);
        verify("short_mab", 0, 0, 1, 1'b0);

        // Random frames, including the empty and single-slot boundaries.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = (r == 0) ? 0 : (r == 1) ? 1 : int'($urandom_range(2, 40));
            randomize_slots(n);
            run_frame($sformatf("rand%0d_n%0d", r, n), n);
        end

        check("no_write_frame_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmx_rx_bus.md
Name: dmx_rx_bus

Overview:
- DMX512 receiver that decodes the DMX_IN line, currently passed straight through, into slot bytes.
- Packs channel bytes in pairs and issues single-cycle writes on the shared 16-bit word write bus, the same address/data/strobe bus the SPI input drives into sram_bus.
- Sits upstream of sram_bus and lets the DMX universe land directly in pixel/config memory.
- Flags frame completion and line errors for status/debug.

Parameters:
CLOCKS_PER_BIT, 192, clk cycles per DMX bit (48 MHz / 250 kbaud)
BREAK_MIN_CYCLES, 4224, minimum continuous low for a valid break (88 us)
MAB_MIN_CYCLES, 384, minimum high after break (8 us)
ADDRESS_BUS_WIDTH, 16, write address width
BASE_ADDRESS, 16'h7F00, word address of channels 1/2
START_CODE, 8'h00, accepted slot-0 start code

Ports:
clk  in  1  system clock (48 MHz HFOSC)
rst  in  1  synchronous, active-high reset
dmx_in  in  1  raw asynchronous DMX line (idle high)
write_address  out  ADDRESS_BUS_WIDTH  word address of write
write_data  out  16  [7:0] = odd channel (1,3,..), [15:8] = even channel (2,4,..)
write_strobe  out  1  one-cycle write qualifier
frame_strobe  out  1  one-cycle pulse at end of an accepted frame
frame_slot_count  out  10  data slots (0..512) in last accepted frame, held
error_strobe  out  1  one-cycle pulse on framing error / short MAB

Behaviour:
- Reset: all outputs 0; state WAIT_BREAK; synchronizer flops 1; counters 0.
- Input: 2-flop synchronizer; all logic uses the synced line (2-cycle input latency).
- Low-run counter: counts consecutive synced-low cycles, saturates at BREAK_MIN_CYCLES, clears on high. Reaching BREAK_MIN_CYCLES from any state:
  - ends the current frame (flush + frame_strobe if in DATA_SLOTS);
  - then enters BREAK.
- States:
  - WAIT_BREAK: ignore line until break detected.
  - BREAK: wait for line high, then MAB; MAB counter starts at 0.
  - MAB: high for MAB_MIN_CYCLES -> START_SLOT. Low earlier -> error_strobe, WAIT_BREAK.
  - START_SLOT / DATA_SLOTS: UART receive, 8N2, LSB first.
    - Falling edge -> wait CLOCKS_PER_BIT/2; line must still be low, else glitch, resume idle in same state.
    - Sample 8 data bits, each CLOCKS_PER_BIT apart.
    - Sample stop bit one bit later: high = byte valid; low = error_strobe, WAIT_BREAK, pending byte discarded, no frame_strobe. A real break still ends the frame via the low-run counter first if it fires.
  - START_SLOT byte != START_CODE: go to WAIT_BREAK silently (no error). Byte == START_CODE -> DATA_SLOTS, slot index d = 0.
- Packing, d = 0..511:
  - Even d: latch byte as pending low byte.
  - Odd d: write_data = {byte, pending}, write_address = BASE_ADDRESS + (d>>1), write_strobe high one cycle, the cycle after the stop-bit sample.
  - d++ after each byte.
- Frame end:
  - d reaches 512 (slot 512 written) -> frame_strobe, frame_slot_count = 512, WAIT_BREAK.
  - Break during DATA_SLOTS -> if pending low byte exists, write {8'h00, pending} first. frame_strobe follows one cycle after that write, or on the break-detect cycle if nothing pending. frame_slot_count = d.
  - Frame of 0 data slots: frame_strobe, count 0, no writes.
- Writes and frame_strobe are never asserted in the same cycle. Max one write per two byte times. No backpressure: the bus must accept every strobe.
- Address arithmetic modulo 2^ADDRESS_BUS_WIDTH; no wrap inside one frame at default base.
- rst mid-frame: immediate return to reset values; no flush write, no strobes.

Decomposition:
- Shared package/header (functions.vh companion): DMX timing constants (CLOCKS_PER_BIT, BREAK_MIN_CYCLES, MAB_MIN_CYCLES), state encoding localparams, DMX_MAX_SLOTS = 512.
- One sub-module: dmx_uart_rx.
  - Contents: synchronizer, mid-bit sampling, stop check.
  - Outputs: byte_valid strobe, byte, framing_error strobe.
- The frame/break/packing FSM stays in dmx_rx_bus.

Test Plan:
1. Break 100 us, MAB 12 us, start 0x00, slots 0x11,0x22,0x33,0x44, then break -> writes (0x7F00, 0x2211), (0x7F01, 0x4433); frame_strobe; count 4.
2. Same with 3 slots 0xAA,0xBB,0xCC then break -> writes (0x7F00, 0xBBAA), then (0x7F01, 0x00CC); frame_strobe the next cycle; count 3.
3. Full 512-slot frame, slot n = n[7:0] -> 256 writes, last (0x7FFF, 0x00FF); frame_strobe right after; count 512; no further writes until the next break.
4. Start code 0xCC, then 4 slots -> no writes, no frame_strobe, no error_strobe. The next valid frame is received normally.
5. Slot 2 sent with low stop bit (line then high) -> error_strobe once; only writes before it occur; no frame_strobe. Break of 80 us -> ignored. MAB of 4 us -> error_strobe.
6. Assert rst during slot 5 of a frame -> all outputs 0 next cycle, no flush write. After release, the next full frame is decoded correctly.
